dct_coeff_mac: RTL and testbench

DCT_COEFF_MAC -- requirements
Module: dct_coeff_mac

---
 rtl/dct_pkg.sv | 15 +
 rtl/dct_coeff_mac.sv | 94 +++++++++
 tb/tb_dct_coeff_mac.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared widths, level shift and FSM encoding for the 8x8 DCT coefficient MAC.
package dct_pkg;
  localparam int PIX_W             = 8;
  localparam int COEF_W            = 16;
  localparam int ACC_W             = 32;
  localparam int IDX_W             = 6;
  localparam int LEVEL_SHIFT       = 128;
  localparam int FRAC_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_e;
endpackage

// File: rtl/dct_coeff_mac.sv
// 8x8 DCT MAC: one coefficient per 64 pixels, coef_valid 2 cycles after the 64th pixel (DCT_MAC_ROUND_EN: round half up).
// Coefficient held until coef_ready; pix_ready stays low from the 64th pixel until the coefficient is taken.
module dct_coeff_mac #(
  parameter int FRAC_BITS = dct_pkg::FRAC_BITS_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pix_valid,
  input  logic        [dct_pkg::PIX_W-1:0]  pix_data,
  output logic                              pix_ready,
  output logic        [2:0]                 lut_n1,
  output logic        [2:0]                 lut_n2,
  input  logic signed [dct_pkg::ACC_W-1:0]  cos_term,
  output logic                              coef_valid,
  output logic signed [dct_pkg::COEF_W-1:0] coef_data,
  input  logic                              coef_ready
);
  import dct_pkg::*;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  prod_q, prod_d;
  logic                     prod_v_q, prod_v_d;
  logic signed [ACC_W-1:0]  pix_ext;
  logic                     accept;

`ifdef DCT_MAC_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC_BITS - 1);
`endif

  assign accept  = pix_valid && pix_ready;
  assign pix_ext = $signed({{(ACC_W - PIX_W){1'b0}}, pix_data}) - ACC_W'(LEVEL_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && (idx_q == '1)) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     if (coef_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // pix_ready is gated by rst so the block shows idle while reset is held.
  always_comb begin
    pix_ready  = !rst && (state_q == ACCUM);
    coef_valid = (state_q == OUT);
    lut_n1     = idx_q[5:3];
    lut_n2     = idx_q[2:0];
`ifdef DCT_MAC_ROUND_EN
    coef_data  = COEF_W'((acc_q + HALF) >>> FRAC_BITS);
`else
    coef_data  = COEF_W'(acc_q >>> FRAC_BITS);
`endif
  end

  // The last product lands in acc during DRAIN, so acc is final on entry to OUT.
  always_comb begin
    idx_d    = idx_q;
    prod_d   = prod_q;
    prod_v_d = 1'b0;
    acc_d    = acc_q;
    if (prod_v_q) acc_d = acc_q + prod_q;
    if (accept) begin
      idx_d    = idx_q + IDX_W'(1);
      prod_d   = pix_ext * cos_term;
      prod_v_d = 1'b1;
    end
    if ((state_q == OUT) && coef_ready) acc_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
    end
  end
endmodule

// File: tb/tb_dct_coeff_mac.sv
// Directed bench for dct_coeff_mac: external cosine LUT modelled by a table, expected coefficients hand-derived.
module tb_dct_coeff_mac;
  localparam int FB = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               pix_valid;
  logic        [7:0]  pix_data;
  logic               pix_ready;
  logic        [2:0]  lut_n1;
  logic        [2:0]  lut_n2;
  logic signed [31:0] cos_term;
  logic               coef_valid;
  logic signed [15:0] coef_data;
  logic               coef_ready;

  int lut [64];
  int pix [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb cos_term = 32'(lut[{lut_n1, lut_n2}]);

  dct_coeff_mac #(.FRAC_BITS(FB)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .lut_n1     (lut_n1),
    .lut_n2     (lut_n2),
    .cos_term   (cos_term),
    .coef_valid (coef_valid),
    .coef_data  (coef_data),
    .coef_ready (coef_ready)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model();
    longint s = 0;
    for (int i = 0; i < 64; i++) s += longint'(pix[i] - 128) * longint'(lut[i]);
`ifdef DCT_MAC_ROUND_EN
    s += longint'(1) << (FB - 1);
`endif
    return int'(s >>> FB);
  endfunction

  // Feeds pixels 0..n-1; returns at the negedge of the cycle after the last acceptance.
  task automatic send_block(input bit gaps, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int idle = $urandom_range(0, 3);
        for (int g = 0; g < idle; g++) begin
          @(negedge clk);
          pix_valid = 1'b0;
        end
      end
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = pix[i][7:0];
      chk("lut_idx", {lut_n1, lut_n2}, i);
      chk("pix_ready", pix_ready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  // Starts in the DRAIN cycle; holds coef_ready low for `hold` cycles with pix_valid pushed.
  task automatic finish_block(input int exp, input int hold);
    chk("drain_vld", coef_valid, 0);
    chk("drain_rdy", pix_ready, 0);
    @(negedge clk);
    chk("out_vld", coef_valid, 1);
    chk("coef", coef_data, exp);
    pix_valid = (hold > 0);
    pix_data  = 8'hFF;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_vld", coef_valid, 1);
      chk("hold_coef", coef_data, exp);
      chk("hold_rdy", pix_ready, 0);
    end
    pix_valid  = 1'b0;
    coef_ready = 1'b1;
    @(negedge clk);
    coef_ready = 1'b0;
    chk("post_vld", coef_valid, 0);
    chk("post_rdy", pix_ready, 1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_coef_valid"}, coef_valid, 0);
    chk({tag, "_coef_data"}, coef_data, 0);
    chk({tag, "_lut"}, {lut_n1, lut_n2}, 0);
  endtask

  initial begin
    int exp_v;
    rst        = 1'b1;
    pix_valid  = 1'b0;
    pix_data   = 8'd0;
    coef_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      lut[i] = 0;
      pix[i] = 128;
    end
    #12;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // All mid-grey: zero coefficient.
    for (int i = 0; i < 64; i++) lut[i] = 1000;
    send_block(1'b0, 64);
    finish_block(0, 0);

    // (1,0)=255 with cos -246: -31242 -> -123 floor / -122 rounded; also the hold test.
    for (int i = 0; i < 64; i++) lut[i] = 77;
    lut[8] = -246;
    pix[8] = 255;
`ifdef DCT_MAC_ROUND_EN
    exp_v = -122;
`else
    exp_v = -123;
`endif
    send_block(1'b0, 64);
    finish_block(exp_v, 5);

    // (0,0)=0 with cos 139: -17792 -> -70 floor / -69 rounded.
    for (int i = 0; i < 64; i++) begin
      lut[i] = -50;
      pix[i] = 128;
    end
    lut[0] = 139;
    pix[0] = 0;
`ifdef DCT_MAC_ROUND_EN
    exp_v = -69;
`else
    exp_v = -70;
`endif
    send_block(1'b0, 64);
    finish_block(exp_v, 0);

    // Mixed pattern, once gap-free and once with random idle cycles.
    for (int i = 0; i < 64; i++) begin
      pix[i] = (i * 37 + 11) % 256;
      lut[i] = ((i * 13) % 41 - 20) * 7;
    end
    exp_v = model();
    send_block(1'b0, 64);
    finish_block(exp_v, 0);
    send_block(1'b1, 64);
    finish_block(exp_v, 2);

    // Reset after 30 pixels of the (0,0) block; the rerun must not include them.
    for (int i = 0; i < 64; i++) begin
      lut[i] = -50;
      pix[i] = 128;
    end
    lut[0] = 139;
    pix[0] = 0;
`ifdef DCT_MAC_ROUND_EN
    exp_v = -69;
`else
    exp_v = -70;
`endif
    send_block(1'b0, 30);
    rst = 1'b1;
    #1;
    check_idle("midrst");
    @(negedge clk);
    rst = 1'b0;
    send_block(1'b0, 64);
    finish_block(exp_v, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
